// File: rtl/receiver_pkg.sv
// Shared definitions for the two-wire bus receiver and its companion transmitter.
package receiver_pkg;

  localparam int unsigned DEF_BUS_WIDTH = 8;
  localparam int unsigned DEF_CNT_WIDTH = 4;
  localparam logic [6:0]  DEF_OWN_ADDR  = 7'h68;
  localparam int unsigned ADDR_BITS     = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK,
    ST_DATA,
    ST_IGNORE
  } rx_state_e;

  function automatic logic addr_match(input logic [6:0] addr, input logic [6:0] own);
    return addr == own;
  endfunction

endpackage

// File: rtl/receiver_line_sync.sv
// Two-flop synchronizer plus history flop for one bus line, with edge strobes.
module line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic line_s,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic hist_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      hist_q <= 1'b1;
    end else begin
      meta_q <= line;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  assign line_s = sync_q;
  assign rise   = sync_q & ~hist_q;
  assign fall   = ~sync_q & hist_q;

endmodule

// File: rtl/receiver.sv
// Two-wire bus slave receiver: START/STOP detection, address match with ACK,
// and unacknowledged data byte capture.
module receiver
  import receiver_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = DEF_BUS_WIDTH,
  parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH,
  parameter logic [6:0]  OWN_ADDR  = DEF_OWN_ADDR
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 scl,
  input  logic                 sda,
  output logic                 sda_pull_low,
  output logic [6:0]           addr_out,
  output logic                 rw_out,
  output logic                 addr_valid,
  output logic [BUS_WIDTH-1:0] data_out,
  output logic                 data_valid,
  output logic                 is_busy,
  output logic                 frame_err
);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;

  line_sync u_scl_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .line  (scl),
    .line_s(scl_s),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  line_sync u_sda_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .line  (sda),
    .line_s(sda_s),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  logic scl_high_stable;
  logic start_det;
  logic stop_det;

  assign scl_high_stable = scl_s & ~scl_rise;
  assign start_det       = scl_high_stable & sda_fall;
  assign stop_det        = scl_high_stable & sda_rise;

  rx_state_e              state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [BUS_WIDTH-2:0]   shift_q, shift_d;
  logic                   open_q, open_d;
  logic                   skip_q, skip_d;
  logic                   pull_q, pull_d;
  logic                   busy_q, busy_d;
  logic [6:0]             addr_q, addr_d;
  logic                   rw_q, rw_d;
  logic                   av_q, av_d;
  logic [BUS_WIDTH-1:0]   data_q, data_d;
  logic                   dv_q, dv_d;
  logic                   ferr_q, ferr_d;

  logic [ADDR_BITS-1:0]   addr_byte;
  logic [BUS_WIDTH-1:0]   data_byte;
  logic                   partial_byte;

  assign addr_byte = {shift_q[6:0], sda_s};
  assign data_byte = {shift_q, sda_s};

  // Every STOP is preceded by its own scl rise, which gets sampled as a bit;
  // that still-open bit is not evidence of a truncated byte.
  assign partial_byte = (cnt_q != '0) && !((cnt_q == CNT_WIDTH'(1)) && open_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    open_d  = open_q;
    skip_d  = skip_q;
    pull_d  = pull_q;
    busy_d  = busy_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    av_d    = 1'b0;
    data_d  = data_q;
    dv_d    = 1'b0;
    ferr_d  = 1'b0;

    if (scl_fall) begin
      open_d = 1'b0;
    end

    if (stop_det) begin
      if (state_q != ST_IDLE) begin
        if ((state_q == ST_ADDR || state_q == ST_DATA) && partial_byte) begin
          ferr_d = 1'b1;
        end
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        pull_d  = 1'b0;
        cnt_d   = '0;
        shift_d = '0;
        open_d  = 1'b0;
        skip_d  = 1'b0;
      end
    end else if (start_det) begin
      state_d = ST_ADDR;
      busy_d  = 1'b1;
      pull_d  = 1'b0;
      cnt_d   = '0;
      shift_d = '0;
      open_d  = 1'b0;
      skip_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
        end

        ST_ADDR: begin
          if (scl_rise) begin
            if (cnt_q == CNT_WIDTH'(ADDR_BITS - 1)) begin
              addr_d  = addr_byte[7:1];
              rw_d    = addr_byte[0];
              av_d    = 1'b1;
              cnt_d   = '0;
              state_d = addr_match(addr_byte[7:1], OWN_ADDR) ? ST_ACK : ST_IGNORE;
            end else begin
              shift_d = {shift_q[BUS_WIDTH-3:0], sda_s};
              cnt_d   = cnt_q + CNT_WIDTH'(1);
              open_d  = 1'b1;
            end
          end
        end

        // First fall ends the 8th clock and starts driving; the next fall
        // ends the 9th clock and releases the line.
        ST_ACK: begin
          if (scl_fall) begin
            if (!pull_q) begin
              pull_d = 1'b1;
            end else begin
              pull_d  = 1'b0;
              state_d = ST_DATA;
              cnt_d   = '0;
            end
          end
        end

        ST_DATA: begin
          if (scl_rise) begin
            if (skip_q) begin
              skip_d = 1'b0;
            end else if (cnt_q == CNT_WIDTH'(BUS_WIDTH - 1)) begin
              data_d = data_byte;
              dv_d   = 1'b1;
              cnt_d  = '0;
              skip_d = 1'b1;
            end else begin
              shift_d = {shift_q[BUS_WIDTH-3:0], sda_s};
              cnt_d   = cnt_q + CNT_WIDTH'(1);
              open_d  = 1'b1;
            end
          end
        end

        ST_IGNORE: begin
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      open_q  <= 1'b0;
      skip_q  <= 1'b0;
      pull_q  <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      av_q    <= 1'b0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      open_q  <= open_d;
      skip_q  <= skip_d;
      pull_q  <= pull_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      av_q    <= av_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      ferr_q  <= ferr_d;
    end
  end

  assign sda_pull_low = pull_q;
  assign addr_out     = addr_q;
  assign rw_out       = rw_q;
  assign addr_valid   = av_q;
  assign data_out     = data_q;
  assign data_valid   = dv_q;
  assign is_busy      = busy_q;
  assign frame_err    = ferr_q;

endmodule

// File: tb/tb_receiver.sv
// Bench for receiver: bit-banged bus master, event monitor and a frame-level
// expectation model.
module tb_receiver;

  localparam logic [6:0] OWN = 7'h68;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_pull_low;
  logic [6:0] addr_out;
  logic       rw_out;
  logic       addr_valid;
  logic [7:0] data_out;
  logic       data_valid;
  logic       is_busy;
  logic       frame_err;

  assign sda_line = sda_m & ~sda_pull_low;

  always #5 clk = ~clk;

  receiver #(.BUS_WIDTH(8), .CNT_WIDTH(4), .OWN_ADDR(7'h68)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scl         (scl),
    .sda         (sda_line),
    .sda_pull_low(sda_pull_low),
    .addr_out    (addr_out),
    .rw_out      (rw_out),
    .addr_valid  (addr_valid),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .is_busy     (is_busy),
    .frame_err   (frame_err)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] got_addr[$];
  logic [7:0] got_data[$];
  logic [7:0] exp_addr[$];
  logic [7:0] exp_data[$];
  logic [7:0] tx_bytes[$];
  int         got_ferr = 0;
  int         got_pull = 0;
  int         exp_ferr = 0;
  int         exp_pull = 0;
  logic [6:0] last_addr = '0;
  logic       last_rw = 1'b0;
  logic [7:0] last_data = '0;
  int         busy_lat = 0;

  always @(negedge clk) begin
    if (addr_valid) got_addr.push_back({addr_out, rw_out});
    if (data_valid) got_data.push_back(data_out);
    if (frame_err) got_ferr++;
    if (sda_pull_low) got_pull++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    scl = 1'b0; wait_clk(4);
    sda_m = 1'b1; wait_clk(4);
    scl = 1'b1; wait_clk(4);
    sda_m = 1'b0; wait_clk(8);
  endtask

  task automatic send_bit(input logic b);
    scl = 1'b0; wait_clk(4);
    sda_m = b; wait_clk(4);
    scl = 1'b1; wait_clk(8);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    scl = 1'b0; wait_clk(4);
    sda_m = 1'b1; wait_clk(4);
    scl = 1'b1; wait_clk(4);
    ack = (sda_line === 1'b0);
    wait_clk(4);
  endtask

  task automatic bus_stop();
    scl = 1'b0; wait_clk(4);
    sda_m = 1'b0; wait_clk(4);
    scl = 1'b1; wait_clk(8);
    sda_m = 1'b1;
    busy_lat = 99;
    for (int i = 1; i <= 10; i++) begin
      wait_clk(1);
      if (!is_busy) begin
        busy_lat = i;
        break;
      end
    end
    wait_clk(8);
  endtask

  task automatic clear_obs();
    got_addr.delete(); got_data.delete(); exp_addr.delete(); exp_data.delete();
    got_ferr = 0; got_pull = 0; exp_ferr = 0; exp_pull = 0;
  endtask

  // One address phase plus the bytes in tx_bytes and an optional truncated tail.
  task automatic model_segment(input logic [6:0] a, input logic rw, input int partial);
    exp_addr.push_back({a, rw});
    last_addr = a;
    last_rw   = rw;
    if (a == OWN) begin
      exp_pull += 16;
      foreach (tx_bytes[i]) begin
        exp_data.push_back(tx_bytes[i]);
        last_data = tx_bytes[i];
      end
      if (partial > 0) exp_ferr++;
    end
  endtask

  task automatic check_frame(input string tag);
    chk({tag, ".n_addr"}, 32'(got_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++)
      chk($sformatf("%s.addr%0d", tag, i), 32'(got_addr[i]), 32'(exp_addr[i]));
    chk({tag, ".n_data"}, 32'(got_data.size()), 32'(exp_data.size()));
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++)
      chk($sformatf("%s.data%0d", tag, i), 32'(got_data[i]), 32'(exp_data[i]));
    chk({tag, ".ferr"}, 32'(got_ferr), 32'(exp_ferr));
    chk({tag, ".pull_cycles"}, 32'(got_pull), 32'(exp_pull));
    chk({tag, ".addr_out"}, 32'(addr_out), 32'(last_addr));
    chk({tag, ".rw_out"}, 32'(rw_out), 32'(last_rw));
    chk({tag, ".data_out"}, 32'(data_out), 32'(last_data));
    chk({tag, ".idle_busy"}, 32'(is_busy), 32'(0));
  endtask

  task automatic run_frame(input string tag, input logic [6:0] a, input logic rw,
                           input int partial_n, input logic [7:0] partial_v);
    logic ack;
    clear_obs();
    bus_start();
    chk({tag, ".busy"}, 32'(is_busy), 32'(1));
    send_byte({a, rw}, ack);
    chk({tag, ".addr_ack"}, 32'(ack), 32'(a == OWN));
    foreach (tx_bytes[i]) begin
      send_byte(tx_bytes[i], ack);
      chk($sformatf("%s.data_ack%0d", tag, i), 32'(ack), 32'(0));
    end
    for (int i = 0; i < partial_n; i++) send_bit(partial_v[7-i]);
    bus_stop();
    chk({tag, ".busy_lat_le3"}, 32'(busy_lat <= 3), 32'(1));
    wait_clk(4);
    model_segment(a, rw, partial_n);
    check_frame(tag);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".pull"}, 32'(sda_pull_low), 32'(0));
    chk({tag, ".addr_out"}, 32'(addr_out), 32'(0));
    chk({tag, ".rw_out"}, 32'(rw_out), 32'(0));
    chk({tag, ".addr_valid"}, 32'(addr_valid), 32'(0));
    chk({tag, ".data_out"}, 32'(data_out), 32'(0));
    chk({tag, ".data_valid"}, 32'(data_valid), 32'(0));
    chk({tag, ".busy"}, 32'(is_busy), 32'(0));
    chk({tag, ".frame_err"}, 32'(frame_err), 32'(0));
  endtask

  initial begin
    logic       ack;
    logic [6:0] ra;
    logic       rrw;
    int         nb;
    int         pn;
    logic [7:0] pv;
    logic [7:0] pat;

    rst_n = 1'b0;
    wait_clk(4);
    check_zero("reset");
    rst_n = 1'b1;
    wait_clk(8);

    tx_bytes.delete();
    run_frame("own_w", OWN, 1'b0, 0, 8'h00);

    tx_bytes = '{8'hA5, 8'h3C};
    run_frame("two_bytes", OWN, 1'b0, 0, 8'h00);

    tx_bytes = '{8'hFF};
    run_frame("foreign", 7'h21, 1'b0, 0, 8'h00);

    tx_bytes.delete();
    run_frame("partial3", OWN, 1'b0, 3, 8'hA0);

    // Repeated start: 0x68 W then 0x68 R in one bus transaction.
    clear_obs();
    tx_bytes.delete();
    bus_start();
    send_byte({OWN, 1'b0}, ack);
    chk("rstart.ack1", 32'(ack), 32'(1));
    model_segment(OWN, 1'b0, 0);
    bus_start();
    chk("rstart.busy", 32'(is_busy), 32'(1));
    send_byte({OWN, 1'b1}, ack);
    chk("rstart.ack2", 32'(ack), 32'(1));
    model_segment(OWN, 1'b1, 0);
    bus_stop();
    wait_clk(4);
    check_frame("rstart");

    // Reset pulse during the low phase of the 5th data bit.
    clear_obs();
    tx_bytes.delete();
    bus_start();
    send_byte({OWN, 1'b0}, ack);
    chk("midrst.ack", 32'(ack), 32'(1));
    model_segment(OWN, 1'b0, 0);
    pat = 8'hB7;
    for (int i = 7; i >= 4; i--) send_bit(pat[i]);
    scl = 1'b0;
    wait_clk(2);
    rst_n = 1'b0;
    wait_clk(1);
    check_zero("midrst");
    rst_n = 1'b1;
    last_addr = '0; last_rw = 1'b0; last_data = '0;
    wait_clk(1);
    sda_m = pat[3];
    wait_clk(1);
    scl = 1'b1;
    wait_clk(8);
    bus_stop();
    wait_clk(4);
    check_frame("midrst");

    tx_bytes = '{8'h5A, 8'h81, 8'h00};
    run_frame("after_rst", OWN, 1'b0, 0, 8'h00);

    for (int f = 0; f < 12; f++) begin
      ra  = ($urandom_range(0, 1) == 1) ? OWN : 7'($urandom_range(0, 127));
      rrw = 1'($urandom_range(0, 1));
      nb  = $urandom_range(0, 3);
      tx_bytes.delete();
      for (int i = 0; i < nb; i++) tx_bytes.push_back(8'($urandom_range(0, 255)));
      pn = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0;
      pv = 8'($urandom_range(0, 255));
      run_frame($sformatf("rnd%0d", f), ra, rrw, pn, pv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/receiver.md
RECEIVER -- requirements
Module: receiver

Interface
REQ-001 Parameter BUS_WIDTH, default 8, byte width on the bus.
REQ-002 Parameter CNT_WIDTH, default 4, bit-counter width; SHALL hold the value BUS_WIDTH.
REQ-003 Parameter OWN_ADDR, default 7'h68, 7-bit address this block acknowledges.
REQ-004 clk  input  1  sole clock; all logic on posedge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 scl  input  1  bus clock line, asynchronous to clk; undriven reads 1.
REQ-007 sda  input  1  bus data line, asynchronous to clk; undriven reads 1.
REQ-008 sda_pull_low  output  1  1 = drive sda low (ACK); 0 = release sda.
REQ-009 addr_out  output  7  last received address.
REQ-010 rw_out  output  1  R/W bit of last address byte.
REQ-011 addr_valid  output  1  one-cycle pulse: addr_out and rw_out updated.
REQ-012 data_out  output  BUS_WIDTH  last received data byte.
REQ-013 data_valid  output  1  one-cycle pulse: data_out updated.
REQ-014 is_busy  output  1  1 from START detect until STOP detect.
REQ-015 frame_err  output  1  one-cycle pulse: STOP arrived mid-byte.

Function
REQ-016 scl and sda SHALL pass through a 2-flop synchronizer plus one history flop; all decisions use synchronized values (scl_s, sda_s) and their previous samples.
REQ-017 START = sda_s 1->0 while scl_s is 1 in both current and previous samples; STOP = sda_s 0->1 under the same scl condition.
REQ-018 Bit sample = scl_s 0->1; sda_s is shifted into the shift register MSB first.
REQ-019 States: IDLE, ADDR, ACK, DATA, IGNORE.
REQ-020 IDLE: wait for START; START -> ADDR, bit counter = 0, is_busy = 1 on the next cycle.
REQ-021 ADDR: after 8 samples, pulse addr_valid one cycle later with addr_out = bits[7:1] and rw_out = bits[0]; address == OWN_ADDR -> ACK, else -> IGNORE.
REQ-022 ACK: sda_pull_low = 1 from the next scl_s falling edge through the following scl_s falling edge (9th bus clock); then sda_pull_low = 0 -> DATA, counter = 0.
REQ-023 DATA: after BUS_WIDTH samples, pulse data_valid one cycle later with data_out = byte, counter = 0, and stay in DATA for further bytes; data bytes are not acknowledged.
REQ-024 IGNORE: no outputs change and sda_pull_low = 0 until STOP or START.
REQ-025 STOP in any non-IDLE state -> IDLE, is_busy = 0, sda_pull_low = 0; if counter is not 0 in ADDR or DATA, pulse frame_err and discard the partial byte.
REQ-026 START in any non-IDLE state (repeated start) -> ADDR with counter cleared; no frame_err.
REQ-027 A START/STOP and a bit sample are mutually exclusive by REQ-017/018, because scl_s cannot be stable-high and rising in the same cycle.
REQ-028 data_out and addr_out hold their value until the next valid byte; a new byte overwrites an unread one without flagging.
REQ-029 Worst-case latency from a raw scl edge to the resulting valid pulse is 4 clk cycles.

Reset
REQ-030 While rst_n = 0 at posedge clk: state = IDLE, counter = 0, shift register = 0, all outputs = 0, and synchronizer and history flops = 1.
REQ-031 Reset asserted mid-frame SHALL abandon the frame without any valid or error pulse; after release, the block waits for a fresh START.

Structure
REQ-032 State encoding, default OWN_ADDR and BUS_WIDTH constants SHALL live in a shared package also used by the transmitter.
REQ-033 Sub-module line_sync SHALL be instantiated once per line (scl, sda), providing the synchronized value plus rise/fall strobes.

Verification
REQ-034 Bus clock of 8 clk per phase. START, address 0x68 with W, STOP -> addr_valid once with addr_out = 0x68 and rw_out = 0; sda_pull_low high for exactly the 9th scl period.
REQ-035 START, 0xD0 (address 0x68, W), data 0xA5, 0x3C, STOP -> two data_valid pulses with data_out 0xA5 then 0x3C; is_busy falls within 3 clk of the STOP edge.
REQ-036 START, address 0x21, data 0xFF, STOP -> addr_valid with addr_out = 0x21; no ACK, no data_valid.
REQ-037 START, 0x68 W with ACK, 3 data bits, STOP -> frame_err pulses once; no data_valid; state returns to IDLE.
REQ-038 START, 0x68 W with ACK, repeated START, 0x68 R -> second addr_valid with rw_out = 1; no frame_err.
REQ-039 rst_n = 0 for 1 cycle during the 5th data bit -> all outputs 0; a following valid frame is received correctly.
